// File: rtl/rr_packet_mux_pkg.sv
// Shared types and default sizes for the round-robin packet multiplexer.
//
// Contents:
//   DEF_NUM_REQ, DEF_DATA_WIDTH, DEF_WDT_CYCLES : default parameter values
//   rr_pmux_state_e                             : packet FSM state
package rr_packet_mux_pkg;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 64;
    localparam int unsigned DEF_WDT_CYCLES = 256;

    typedef enum logic {
        IDLE,
        LOCKED
    } rr_pmux_state_e;

endpackage

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with a rotating priority pointer.
//
// The pointer only moves on an actual grant: after source k wins, the search
// for the next grant starts at k+1 (wrapping to 0).
//
// Ports:
//   clk_i    : clock
//   arst_ni  : asynchronous reset, active low (pointer returns to 0)
//   req_i    : per-source request
//   allow_i  : enables granting; when low no grant and no rotation
//   gnt_o    : one-hot grant, or zero
module round_robin_arbiter
    import rr_packet_mux_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ
) (
    input  logic               clk_i,
    input  logic               arst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               allow_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Search from the pointer upwards; the first requester seen wins.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IDX_W'((32'(ptr_q) + k) % NUM_REQ);
            if (allow_i && !found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                ptr_d      = (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/rr_packet_mux.sv
// N-to-1 valid/ready packet multiplexer with round-robin packet-start
// arbitration and a single registered output slot.
//
// A source wins the embedded arbiter on its first beat and then owns the
// output until its last beat has transferred; other sources are held off.
//
// Optional feature (macro RR_PACKET_MUX_WDT_EN): a stall watchdog that aborts
// a lock after WDT_CYCLES cycles without an owner beat and pulses wdt_err_o.
//
// Ports:
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   in_valid_i     : per-source beat valid
//   in_data_i      : per-source payload
//   in_last_i      : per-source last-beat flag
//   in_ready_o     : per-source ready, one-hot or zero
//   out_valid_o    : output beat valid (registered)
//   out_data_o     : output payload (registered)
//   out_last_o     : output last-beat flag (registered)
//   out_src_o      : source index of the current output beat (registered)
//   out_ready_i    : downstream ready
//   wdt_err_o      : watchdog abort pulse (only with RR_PACKET_MUX_WDT_EN)
module rr_packet_mux
    import rr_packet_mux_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned WDT_CYCLES = DEF_WDT_CYCLES
) (
    input  logic                                clk_i,
    input  logic                                arst_ni,
    input  logic [NUM_REQ-1:0]                  in_valid_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  in_data_i,
    input  logic [NUM_REQ-1:0]                  in_last_i,
    output logic [NUM_REQ-1:0]                  in_ready_o,
    output logic                                out_valid_o,
    output logic [DATA_WIDTH-1:0]               out_data_o,
    output logic                                out_last_o,
    output logic [$clog2(NUM_REQ)-1:0]          out_src_o,
    input  logic                                out_ready_i
`ifdef RR_PACKET_MUX_WDT_EN
    ,
    output logic                                wdt_err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    if (NUM_REQ < 2 || WDT_CYCLES == 0) begin : g_bad_params
        $error("rr_packet_mux: NUM_REQ must be >= 2 and WDT_CYCLES >= 1");
    end

    rr_pmux_state_e state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  out_last_q;
    logic [IDX_W-1:0]      out_src_q;

    logic               slot_free;
    logic               arb_allow;
    logic [NUM_REQ-1:0] gnt;
    logic [IDX_W-1:0]   gnt_idx;
    logic [NUM_REQ-1:0] in_ready;
    logic [IDX_W-1:0]   sel_idx;
    logic               xfer;
    logic               timeout;

    assign slot_free = ~out_valid_q | out_ready_i;
    // Arbitration only happens at packet starts, so the pointer rotates once
    // per packet and is frozen while a source holds the lock.
    assign arb_allow = (state_q == IDLE) & slot_free;

    round_robin_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .req_i   (in_valid_i),
        .allow_i (arb_allow),
        .gnt_o   (gnt)
    );

    // One-hot to index encoder for the grant vector.
    always_comb begin
        gnt_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx = gnt_idx | IDX_W'(i);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (state_q == IDLE) begin
            in_ready = gnt;
        end else if (slot_free) begin
            in_ready[owner_q] = 1'b1;
        end
    end

    assign sel_idx = (state_q == IDLE) ? gnt_idx : owner_q;
    assign xfer    = |(in_valid_i & in_ready);

`ifdef RR_PACKET_MUX_WDT_EN
    localparam int unsigned CNT_W = $clog2(WDT_CYCLES + 1);

    logic [CNT_W-1:0] wdt_cnt_q, wdt_cnt_d;
    logic             wdt_err_q;

    // Counts silent owner cycles; the WDT_CYCLES-th one aborts the lock.
    always_comb begin
        wdt_cnt_d = '0;
        timeout   = 1'b0;
        if (state_q == LOCKED && !in_valid_i[owner_q]) begin
            if (wdt_cnt_q == CNT_W'(WDT_CYCLES - 1)) begin
                timeout = 1'b1;
            end else begin
                wdt_cnt_d = wdt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wdt_cnt_q <= '0;
            wdt_err_q <= 1'b0;
        end else begin
            wdt_cnt_q <= wdt_cnt_d;
            wdt_err_q <= timeout;
        end
    end

    assign wdt_err_o = wdt_err_q;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    owner_d = gnt_idx;
                    // Single-beat packets leave the FSM free to arbitrate again.
                    if (!in_last_i[gnt_idx]) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (xfer && in_last_i[owner_q]) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q <= IDLE;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data_i[sel_idx];
            out_last_q  <= in_last_i[sel_idx];
            out_src_q   <= sel_idx;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign in_ready_o  = in_ready;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_src_o   = out_src_q;

endmodule

// File: tb/tb_rr_packet_mux.sv
module tb_rr_packet_mux;

    localparam int N   = 4;
    localparam int DW  = 64;
    localparam int WDT = 8;

    logic                 clk = 1'b0;
    logic                 arst_ni = 1'b0;
    logic [N-1:0]         in_valid = '0;
    logic [N-1:0][DW-1:0] in_data = '0;
    logic [N-1:0]         in_last = '0;
    logic [N-1:0]         in_ready;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_last;
    logic [1:0]           out_src;
    logic                 out_ready = 1'b0;
`ifdef RR_PACKET_MUX_WDT_EN
    logic                 wdt_err;
`endif

    rr_packet_mux #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .WDT_CYCLES (WDT)
    ) dut (
        .clk_i       (clk),
        .arst_ni     (arst_ni),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_last_i   (in_last),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_data_o  (out_data),
        .out_last_o  (out_last),
        .out_src_o   (out_src),
        .out_ready_i (out_ready)
`ifdef RR_PACKET_MUX_WDT_EN
        ,
        .wdt_err_o   (wdt_err)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            src;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;

    // Reference model: packet-level view (who owns the output, where the
    // round-robin search starts, whether the output slot holds a beat).
    bit locked;
    int owner;
    int next_prio;
    bit slot_full;
    int silent;
    bit err_due;

    // Per-source traffic generators.
    int  rem[N];
    int  seq[N];
    bit  hold[N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every beat accepted downstream must be the next expected one.
    always @(negedge clk) begin
        if (arst_ni && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL out_beat: got src %0d data %0h, expected no beat (t=%0t)",
                         out_src, out_data, $time);
            end else begin
                mon_e = sb.pop_front();
                check("out_data", out_data, mon_e.data);
                check("out_last", 64'(out_last), 64'(mon_e.last));
                check("out_src", 64'(out_src), 64'(mon_e.src));
            end
        end
    end

    task automatic drive(input int vprob, input int maxlen, input int rprob);
        for (int i = 0; i < N; i++) begin
            if (!hold[i]) begin
                if (rem[i] == 0) rem[i] = int'($urandom_range(maxlen, 1));
                hold[i] = ($urandom_range(99) < vprob);
            end
            in_valid[i] = hold[i];
            in_data[i]  = {32'(i), 32'(seq[i])};
            in_last[i]  = (rem[i] == 1);
        end
        out_ready = ($urandom_range(99) < rprob);
    endtask

    task automatic model_step();
        bit           free;
        bit [N-1:0]   exp_ready;
        int           s;
        int           c;
        free      = !slot_full || out_ready;
        exp_ready = '0;
        s         = -1;
        if (!locked) begin
            if (free) begin
                for (int k = 0; k < N; k++) begin
                    c = (next_prio + k) % N;
                    if (in_valid[c] && s < 0) begin
                        s = c;
                        exp_ready[c] = 1'b1;
                    end
                end
            end
        end else if (free) begin
            exp_ready[owner] = 1'b1;
            if (in_valid[owner]) s = owner;
        end
        check("in_ready", 64'(in_ready), 64'(exp_ready));
        check("out_valid", 64'(out_valid), 64'(slot_full));
`ifdef RR_PACKET_MUX_WDT_EN
        check("wdt_err", 64'(wdt_err), 64'(err_due));
        err_due = 1'b0;
        if (locked && !in_valid[owner]) begin
            silent++;
        end else begin
            silent = 0;
        end
`endif
        if (s >= 0) begin
            sb.push_back('{in_data[s], in_last[s], s});
            if (!locked) begin
                owner     = s;
                next_prio = (s + 1) % N;
                locked    = !in_last[s];
            end else if (in_last[s]) begin
                locked = 1'b0;
            end
            hold[s] = 1'b0;
            seq[s]++;
            rem[s]--;
            slot_full = 1'b1;
        end else if (out_ready) begin
            slot_full = 1'b0;
        end
`ifdef RR_PACKET_MUX_WDT_EN
        if (silent == WDT) begin
            locked  = 1'b0;
            silent  = 0;
            err_due = 1'b1;
        end
`endif
    endtask

    task automatic run(input int cycles, input int vprob, input int maxlen, input int rprob);
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            drive(vprob, maxlen, rprob);
            @(negedge clk);
            model_step();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        arst_ni  = 1'b0;
        in_valid = '0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_out_src", 64'(out_src), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        locked    = 1'b0;
        owner     = 0;
        next_prio = 0;
        slot_full = 1'b0;
        silent    = 0;
        err_due   = 1'b0;
        for (int i = 0; i < N; i++) begin
            rem[i]  = 0;
            hold[i] = 1'b0;
        end
        sb.delete();
        repeat (2) @(negedge clk);
        arst_ni = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) seq[i] = 0;
        do_reset();
        // All sources streaming single-beat packets: strict 0,1,2,3 rotation.
        run(40, 100, 1, 100);
        // Mixed packet lengths with random gaps and back-pressure.
        run(600, 60, 4, 70);
        // Long packets with a mostly silent owner.
        run(400, 25, 6, 50);
        // Heavy back-pressure on long packets.
        run(200, 90, 5, 20);
        // Abort mid-packet, then all valid: source 0 must win first.
        run(6, 100, 4, 100);
        do_reset();
        run(30, 100, 1, 100);
        run(200, 70, 4, 80);
        // Drain the output slot and confirm nothing is left outstanding.
        @(posedge clk);
        #1;
        in_valid  = '0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_timeout: got no end of test, expected finish before %0t", $time);
        $fatal(1, "simulation time limit");
    end

endmodule

// File: doc/rr_packet_mux.md
Name: rr_packet_mux

Overview:
- Downstream consumer of round_robin_arbiter: an N-to-1 valid/ready packet multiplexer.
- Uses round-robin grants to pick a source, then locks onto that source until its last beat is transferred.
- Drives a single registered output channel.
- Sits in front of shared resources (memory port, shared bus, common result path) fed by several pipeline requesters.

Parameters:
- NUM_REQ, 4, number of input channels (>=2).
- DATA_WIDTH, 64, payload width per beat.
- WDT_CYCLES, 256, stall limit in cycles; used only with the optional feature.

Ports:
- clk_i  in  1  clock
- arst_ni  in  1  asynchronous reset, active low
- in_valid_i  in  NUM_REQ  per-source beat valid
- in_data_i  in  NUM_REQ x DATA_WIDTH  per-source payload
- in_last_i  in  NUM_REQ  per-source last-beat flag
- in_ready_o  out  NUM_REQ  per-source ready; one-hot or zero
- out_valid_o  out  1  output beat valid
- out_data_o  out  DATA_WIDTH  output payload
- out_last_o  out  1  output last-beat flag
- out_src_o  out  $clog2(NUM_REQ)  index of the source of the current output beat
- out_ready_i  in  1  downstream ready
- wdt_err_o  out  1  watchdog abort pulse; exists only with RR_PACKET_MUX_WDT_EN

Behaviour:
- Reset:
  - out_valid_o=0, out_data_o=0, out_last_o=0, out_src_o=0, in_ready_o=0.
  - State IDLE, owner=0, embedded arbiter rotation index=0.
- Output stage:
  - Single register slot.
  - slot_free = ~out_valid_o | out_ready_i.
  - Input beat i transfers when in_valid_i[i] & in_ready_o[i]; it appears on the output the next cycle (latency 1).
  - Sustained throughput is 1 beat/cycle.
- State IDLE:
  - Arbiter allow_i = slot_free; arbiter req_i = in_valid_i.
  - On grant g (one-hot), in_ready_o = g and the beat transfers in the same cycle.
  - owner <= index(g).
  - If in_last_i[owner] is set, stay IDLE (single-beat packet, next arbitration possible next cycle). Otherwise go to LOCKED.
- State LOCKED:
  - Arbiter allow_i = 0, so the arbiter grants nothing and does not rotate.
  - in_ready_o[owner] = slot_free; all other bits 0.
  - On a transfer with in_last_i[owner]=1, go to IDLE.
  - Beats from non-owners are never accepted.
- Rotation:
  - The arbiter rotates only on an actual grant, i.e. once per packet start.
  - After source k wins, priority order begins at k+1, wrapping to 0.
- Output update:
  - On transfer: out_data_o, out_last_o and out_src_o load from the owner; out_valid_o=1.
  - Else if out_ready_i: out_valid_o=0, data regs hold.
  - Output regs are stable while out_valid_o & ~out_ready_i.
- Simultaneous events:
  - In IDLE, with a full slot and out_ready_i=1, the slot drains and a new beat loads in the same cycle.
  - A grant at the same edge as the last beat of a previous packet completing downstream is legal.
- Idle inputs: no valid inputs in IDLE means no grant and no rotation.
- Reset mid-packet: asynchronous return to reset values. The partially sent packet is dropped without a trailing last; the upstream must also be reset.

Optional Feature:
- Macro RR_PACKET_MUX_WDT_EN.
- When defined:
  - A counter, width $clog2(WDT_CYCLES+1), counts cycles spent in LOCKED with in_valid_i[owner]=0.
  - It clears on any owner beat and on leaving LOCKED.
  - Reaching WDT_CYCLES forces IDLE and pulses wdt_err_o for one cycle.
  - No fake last beat is emitted.
- When undefined:
  - No counter and no wdt_err_o port.
  - LOCKED waits indefinitely for the owner.

Decomposition:
- Package rr_packet_mux_pkg holds:
  - typedef enum logic {IDLE, LOCKED} rr_pmux_state_e.
  - Default width constants.
- Sub-module: one instance of the existing round_robin_arbiter (NUM_REQ) for packet-start selection.
- Source index is derived with the existing encoder.
- Everything else is inline RTL.

Test Plan:
- Arbitration order: NUM_REQ=4, all sources send single-beat packets continuously, out_ready_i=1 -> out_src_o sequence 0,1,2,3,0,1..., one beat/cycle after 1-cycle latency.
- Locking: src1 sends a 3-beat packet (A,B,C, last on C) while src2 is valid throughout -> output A,B,C from src1 contiguously, then src2 beats; in_ready_o[2]=0 until C has transferred.
- Back-pressure: out_ready_i low for 5 cycles mid-packet -> out_data_o stable and in_ready_o=0 during the stall; no beats lost or duplicated (scoreboard by source/sequence number).
- Sparse owner: src0 in LOCKED deasserts valid for 10 cycles while src3 is valid -> no src3 beats until src0's last beat; rotation index unchanged during the lock.
- Reset mid-packet: assert arst_ni=0 during beat 2 of a 4-beat packet -> all outputs 0 immediately; after release, src0 is granted first when all sources are valid.
- With RR_PACKET_MUX_WDT_EN and WDT_CYCLES=8: owner silent 8 cycles -> wdt_err_o pulses one cycle, state returns to IDLE, next valid source is granted.
